// File: rtl/dynamic_node_pkg.sv
// Shared constants for the dynamic-node output arbiter: port indices,
// the "no owner" mux select and the two-state FSM encoding.
package dynamic_node_pkg;

  localparam int unsigned NPORTS = 5;

  localparam logic [2:0] PORT_N = 3'd0;
  localparam logic [2:0] PORT_E = 3'd1;
  localparam logic [2:0] PORT_S = 3'd2;
  localparam logic [2:0] PORT_W = 3'd3;
  localparam logic [2:0] PORT_P = 3'd4;

  localparam logic [2:0] SEL_NONE = 3'd7;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ROUTE = 1'b1;

  // Next port index, wrapping P back to N.
  function automatic logic [2:0] wrap_inc(input logic [2:0] p);
    return (p == PORT_P) ? PORT_N : p + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational 5-way round-robin picker: first candidate found searching
// upward (mod 5) starting one past rr_ptr.
module rr_pick5
  import dynamic_node_pkg::*;
(
  input  logic [4:0] cand,
  input  logic [2:0] rr_ptr,
  output logic [2:0] winner,
  output logic       found
);

  always_comb begin
    logic [2:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      idx = wrap_inc(idx);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/dynamic_output_arbiter.sv
// Wormhole output arbiter: round-robin header arbitration, packet ownership
// until the tail, and credit-based flow control towards the downstream buffer.
module dynamic_output_arbiter
  import dynamic_node_pkg::*;
#(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         req_valid,
  input  logic [4:0]         req_head,
  input  logic [5*LEN_W-1:0] req_len,
  input  logic               yummy_in,
  output logic [4:0]         grant,
  output logic [2:0]         sel,
  output logic               out_valid
);

  localparam int unsigned    CW       = 4;
  localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0]  CRED_ONE = CW'(1);
  localparam logic [LEN_W:0] REM_ONE  = (LEN_W + 1)'(1);

  logic [0:0]       state;
  logic [2:0]       owner;
  logic [2:0]       rr_ptr;
  logic [LEN_W:0]   remaining;
  logic [CW-1:0]    credit;

  logic [4:0]       cand;
  logic [2:0]       winner;
  logic             found;
  logic [LEN_W-1:0] win_len;
  logic             xfer;

  assign cand = req_valid & req_head;

  rr_pick5 u_pick (
    .cand   (cand),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    win_len = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (winner == 3'(i)) win_len = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Outputs depend only on registered state, req_valid and registered credit,
  // so yummy_in never reaches an output combinationally.
  assign xfer      = (state == ST_ROUTE) && req_valid[owner] && (credit != '0);
  assign sel       = (state == ST_ROUTE) ? owner : SEL_NONE;
  assign out_valid = xfer;
  assign grant     = xfer ? (5'b00001 << owner) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= PORT_N;
      remaining <= '0;
      rr_ptr    <= PORT_P;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state     <= ST_ROUTE;
            owner     <= winner;
            remaining <= {1'b0, win_len} + REM_ONE;
            rr_ptr    <= winner;
          end
        end
        default: begin
          if (xfer) begin
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CRED_MAX;
    end else begin
      case ({xfer, yummy_in})
        2'b10:   credit <= credit - CRED_ONE;
        2'b01:   if (credit != CRED_MAX) credit <= credit + CRED_ONE;
        default: credit <= credit;
      endcase
    end
  end

  credit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(yummy_in && !xfer && (credit == CRED_MAX)));

endmodule

// File: doc/dynamic_output_arbiter.md
DYNAMIC_OUTPUT_ARBITER -- requirements
Module: dynamic_output_arbiter

Interface
REQ-001 Parameter CREDITS, default 4: downstream buffer depth in flits; legal range 1..15.
REQ-002 Parameter LEN_W, default 8: width of the header payload-length field.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port req_valid, input, 5: input port i has a flit at its head; bit order is N=0, E=1, S=2, W=3, P=4.
REQ-006 Port req_head, input, 5: head flit of port i is a header; meaningful only when req_valid[i]=1.
REQ-007 Port req_len, input, 5*LEN_W: body-flit count carried in each port's header; slice i is [i*LEN_W +: LEN_W].
REQ-008 Port yummy_in, input, 1: one downstream credit returned this cycle.
REQ-009 Port grant, output, 5: one-hot dequeue pulse; the head flit of port i is consumed this cycle.
REQ-010 Port sel, output, 3: select for the 5:1 output flit mux; 0..4 selects a port, 7 means no owner.
REQ-011 Port out_valid, output, 1: the mux output carries a valid flit this cycle.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and ROUTE.
REQ-013 In IDLE, candidates SHALL be the ports with req_valid[i] & req_head[i].
REQ-014 In IDLE, the winner SHALL be the first candidate found searching upward, mod 5, from rr_ptr+1.
REQ-015 When a winner exists, on the next edge: state SHALL go to ROUTE, owner SHALL be the winner, remaining SHALL be req_len[winner]+1, and rr_ptr SHALL be the winner.
REQ-016 In IDLE: sel SHALL be 7, grant SHALL be 0, out_valid SHALL be 0, and no flit SHALL be consumed.
REQ-017 In ROUTE, sel SHALL equal owner combinationally, every cycle.
REQ-018 In ROUTE, xfer = req_valid[owner] & (credit != 0); when xfer: out_valid=1 and grant = one-hot(owner); otherwise both SHALL be 0.
REQ-019 Each xfer SHALL decrement remaining.
REQ-020 An xfer that occurs with remaining==1 SHALL return the FSM to IDLE on that edge.
REQ-021 Arbitration for the next packet SHALL take one cycle, so there is exactly one bubble between packets.
REQ-022 req_head and req_len SHALL be ignored in ROUTE; ownership holds until the tail (wormhole).
REQ-023 A stall (req_valid[owner]=0 or credit=0) SHALL hold owner and remaining unchanged, for any number of cycles.
REQ-024 credit: -1 on xfer; +1 on yummy_in; unchanged when both occur in the same cycle.
REQ-025 credit SHALL never underflow, by construction.
REQ-026 yummy_in arriving with credit==CREDITS and no xfer is an illegal overflow; credit SHALL saturate at CREDITS and a simulation assertion SHALL fire.
REQ-027 req_len = 2^LEN_W-1 SHALL yield a 2^LEN_W-flit packet; the remaining counter is LEN_W+1 bits wide.
REQ-028 grant SHALL be at most one-hot in every cycle.
REQ-029 Combinational path: req_valid, credit -> grant and out_valid; no combinational path from yummy_in to any output.

Reset
REQ-030 On rst_n low, immediately: state=IDLE, owner=0, remaining=0, credit=CREDITS, rr_ptr=4 (port 0 has first priority).
REQ-031 During reset, outputs SHALL be sel=7, grant=0, out_valid=0.
REQ-032 Reset mid-packet SHALL abandon the packet with no further grant; upstream state is the integrator's concern.
REQ-033 Reset deassertion SHALL be synchronized externally; the block SHALL begin arbitrating on the first edge with rst_n high.

Structure
REQ-034 Shared package dynamic_node_pkg SHALL hold the port index constants (PORT_N..PORT_P), SEL_NONE=3'd7 and the FSM state encoding.
REQ-035 Sub-module rr_pick5 (combinational 5-way round-robin picker: candidates and rr_ptr in, winner index and found out) SHALL be the only child.
REQ-036 sel SHALL drive the existing 5:1 flit mux directly, without retiming.

Verification
REQ-037 Reset, all ports idle -> sel=7, grant=0, credit=4 held for 10 cycles.
REQ-038 Port 2 header with len=3 and flits always valid -> cycles 1..4 after the arbitration cycle show grant=5'b00100, sel=2, out_valid=1; IDLE after 4 flits.
REQ-039 Ports 0, 1 and 4 request headers continuously with len=0 -> win order 0, 1, 4, 0, 1, 4.
REQ-040 CREDITS=4, no yummy_in, len=7 -> exactly 4 flits then stall; each single yummy_in pulse releases exactly one more flit.
REQ-041 yummy_in coincides with xfer at credit=1 -> credit stays 1; the next cycle transfers.
REQ-042 rst_n asserted after flit 2 of a len=5 packet -> same-cycle IDLE, sel=7, credit=4; port 0 wins the first subsequent contest against port 3.
